// File: rtl/fetch_stage_if.sv
// fetch_stage_if: controller, redirect, program-load and f_* bundle signals of the fetch stage
interface fetch_stage_if;
    logic        F_stall_i;
    logic [3:0]  M_icode_i;
    logic        M_Cnd_i;
    logic [63:0] M_valA_i;
    logic [3:0]  W_icode_i;
    logic [63:0] W_valM_i;
    logic        imem_we_i;
    logic [63:0] imem_waddr_i;
    logic [7:0]  imem_wdata_i;
    logic [63:0] f_pc_o;
    logic [3:0]  f_icode_o;
    logic [3:0]  f_ifun_o;
    logic [3:0]  f_rA_o;
    logic [3:0]  f_rB_o;
    logic [63:0] f_valC_o;
    logic [63:0] f_valP_o;
    logic [2:0]  f_stat_o;
    logic [63:0] f_predPC_o;
    logic [63:0] F_predPC_o;
    modport slave (
        input  F_stall_i, M_icode_i, M_Cnd_i, M_valA_i, W_icode_i, W_valM_i,
               imem_we_i, imem_waddr_i, imem_wdata_i,
        output f_pc_o, f_icode_o, f_ifun_o, f_rA_o, f_rB_o, f_valC_o, f_valP_o,
               f_stat_o, f_predPC_o, F_predPC_o
    );
    modport master (
        output F_stall_i, M_icode_i, M_Cnd_i, M_valA_i, W_icode_i, W_valM_i,
               imem_we_i, imem_waddr_i, imem_wdata_i,
        input  f_pc_o, f_icode_o, f_ifun_o, f_rA_o, f_rB_o, f_valC_o, f_valP_o,
               f_stat_o, f_predPC_o, F_predPC_o
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: Y86-64 fetch with F register, PC select, byte-addressed imem and instruction split
module fetch_stage #(
    parameter int          IMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input logic          clk_i,
    input logic          rst_i,
    fetch_stage_if.slave bus
);
    localparam int          AW      = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [63:0] MEM_TOP = 64'(IMEM_BYTES);
    localparam logic [3:0]  I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
                            I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7,
                            I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB,
                            R_NONE = 4'hF;
    localparam logic [2:0]  SAOK = 3'd1, SHLT = 3'd2, SADR = 3'd3, SINS = 3'd4;

    logic [7:0]  mem [IMEM_BYTES];
    logic [7:0]  b [10];
    logic [63:0] F_predPC, pc, valc, valp;
    logic [64:0] last;
    logic [3:0]  icode, ifun, len;
    logic        invalid, has_reg, has_const, jump, err;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) F_predPC <= RESET_PC;
        else if (!bus.F_stall_i) F_predPC <= bus.f_predPC_o;

    always_ff @(posedge clk_i)
        if (bus.imem_we_i && bus.imem_waddr_i < MEM_TOP) mem[bus.imem_waddr_i[AW-1:0]] <= bus.imem_wdata_i;

    assign pc = (bus.M_icode_i == I_JXX && !bus.M_Cnd_i) ? bus.M_valA_i :
                (bus.W_icode_i == I_RET) ? bus.W_valM_i : F_predPC;

    // Bytes past the end of memory read as zero; err flags any instruction that reaches them.
    for (genvar i = 0; i < 10; i++) begin : g_byte
        logic [63:0] a;
        assign a    = pc + 64'(i);
        assign b[i] = (a < MEM_TOP) ? mem[a[AW-1:0]] : 8'h00;
    end

    assign icode     = b[0][7:4];
    assign ifun      = b[0][3:0];
    assign invalid   = icode > I_POPQ;
    assign jump      = icode inside {I_JXX, I_CALL};
    assign has_const = icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ};
    assign has_reg   = has_const || icode inside {I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ};
    assign len       = has_const ? 4'd10 : jump ? 4'd9 : has_reg ? 4'd2 : 4'd1;
    // 65-bit sum so a last byte wrapping past 2^64 shows up as a carry.
    assign last      = {1'b0, pc} + 65'(len) - 65'd1;
    assign err       = last[64] || last[63:0] >= MEM_TOP;
    assign valc      = has_const ? {b[9], b[8], b[7], b[6], b[5], b[4], b[3], b[2]} :
                       jump      ? {b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1]} : 64'h0;
    assign valp      = pc + 64'(len);

    assign bus.f_pc_o     = pc;
    assign bus.f_icode_o  = err ? I_NOP : icode;
    assign bus.f_ifun_o   = err ? 4'h0 : ifun;
    assign bus.f_rA_o     = (err || !has_reg) ? R_NONE : b[1][7:4];
    assign bus.f_rB_o     = (err || !has_reg) ? R_NONE : b[1][3:0];
    assign bus.f_valC_o   = err ? 64'h0 : valc;
    assign bus.f_valP_o   = err ? pc + 64'd1 : valp;
    assign bus.f_stat_o   = err ? SADR : invalid ? SINS : (icode == I_HALT) ? SHLT : SAOK;
    assign bus.f_predPC_o = (!err && jump) ? valc : bus.f_valP_o;
    assign bus.F_predPC_o = F_predPC;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random and directed stimulus checked every cycle against a byte-array fetch model
module tb_fetch_stage;
    localparam int          IMEM = 1024;
    localparam logic [63:0] RPC  = 64'h0;

    typedef struct {
        logic [63:0] pc;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [2:0]  stat;
        logic [63:0] pred;
    } fexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0]  mm [IMEM];
    logic [63:0] mF;
    logic [63:0] held;
    fexp_t ce;
    int  n_chk = 0;
    int  n_fail = 0;
    bit  check_en = 1'b0;

    fetch_stage_if bus();
    fetch_stage #(.IMEM_BYTES(IMEM), .RESET_PC(RPC)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd(input logic [63:0] a);
        return (a < 64'(IMEM)) ? mm[a[9:0]] : 8'h00;
    endfunction

    function automatic int ilen(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:        return 1;
            4'h2, 4'h6, 4'hA, 4'hB:  return 2;
            4'h7, 4'h8:              return 9;
            4'h3, 4'h4, 4'h5:        return 10;
            default:                 return 1;
        endcase
    endfunction

    function automatic fexp_t model(input logic [63:0] pc);
        fexp_t e;
        logic [7:0] b0, b1;
        logic [3:0] ic;
        int n, off;
        b0 = rd(pc);
        b1 = rd(pc + 64'd1);
        ic = b0[7:4];
        n = ilen(ic);
        e.pc = pc;
        if (64'(n) > 64'(IMEM) || pc > 64'(IMEM - n)) begin
            e.icode = 4'h1; e.ifun = 4'h0; e.ra = 4'hF; e.rb = 4'hF; e.valc = 64'h0;
            e.valp = pc + 64'd1; e.stat = 3'd3; e.pred = pc + 64'd1;
            return e;
        end
        e.icode = ic;
        e.ifun = b0[3:0];
        e.ra = (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) ? b1[7:4] : 4'hF;
        e.rb = (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) ? b1[3:0] : 4'hF;
        off = (ic inside {4'h3, 4'h4, 4'h5}) ? 2 : (ic inside {4'h7, 4'h8}) ? 1 : 0;
        e.valc = 64'h0;
        if (off != 0)
            for (int k = 0; k < 8; k++) e.valc[8*k +: 8] = rd(pc + 64'(off + k));
        e.valp = pc + 64'(n);
        e.stat = (ic > 4'hB) ? 3'd4 : (ic == 4'h0) ? 3'd2 : 3'd1;
        e.pred = (ic inside {4'h7, 4'h8}) ? e.valc : e.valp;
        return e;
    endfunction

    function automatic logic [63:0] sel();
        if (bus.M_icode_i == 4'h7 && !bus.M_Cnd_i) return bus.M_valA_i;
        if (bus.W_icode_i == 4'h9) return bus.W_valM_i;
        return mF;
    endfunction

    always @(posedge clk or posedge rst)
        if (rst) mF <= RPC;
        else if (!bus.F_stall_i) mF <= model(sel()).pred;

    always @(posedge clk)
        if (bus.imem_we_i && bus.imem_waddr_i < 64'(IMEM)) mm[bus.imem_waddr_i[9:0]] <= bus.imem_wdata_i;

    always @(negedge clk)
        if (check_en) begin
            ce = model(sel());
            chk("f_pc", bus.f_pc_o, ce.pc);
            chk("f_icode", 64'(bus.f_icode_o), 64'(ce.icode));
            chk("f_ifun", 64'(bus.f_ifun_o), 64'(ce.ifun));
            chk("f_rA", 64'(bus.f_rA_o), 64'(ce.ra));
            chk("f_rB", 64'(bus.f_rB_o), 64'(ce.rb));
            chk("f_valC", bus.f_valC_o, ce.valc);
            chk("f_valP", bus.f_valP_o, ce.valp);
            chk("f_stat", 64'(bus.f_stat_o), 64'(ce.stat));
            chk("f_predPC", bus.f_predPC_o, ce.pred);
            chk("F_predPC", bus.F_predPC_o, mF);
        end

    task automatic wr(input logic [63:0] a, input logic [7:0] d);
        bus.imem_we_i = 1'b1;
        bus.imem_waddr_i = a;
        bus.imem_wdata_i = d;
        @(posedge clk);
        #2;
        bus.imem_we_i = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic redirect(input logic [63:0] a);
        bus.M_icode_i = 4'h7;
        bus.M_Cnd_i = 1'b0;
        bus.M_valA_i = a;
        settle();
    endtask

    function automatic logic [63:0] rpc();
        case ($urandom_range(3))
            0:       return 64'($urandom_range(IMEM - 1));
            1:       return 64'(IMEM - int'($urandom_range(12, 1)));
            2:       return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    logic [7:0] p_irm [10] = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] p_jxx [9]  = '{8'h70, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        bus.F_stall_i = 1'b0; bus.M_icode_i = 4'h0; bus.M_Cnd_i = 1'b0; bus.M_valA_i = 64'h0;
        bus.W_icode_i = 4'h0; bus.W_valM_i = 64'h0;
        bus.imem_we_i = 1'b0; bus.imem_waddr_i = 64'h0; bus.imem_wdata_i = 8'h0;
        @(posedge clk);
        #2;
        for (int a = 0; a < IMEM; a++) wr(64'(a), 8'($urandom));
        for (int k = 0; k < 10; k++) wr(64'(k), p_irm[k]);
        for (int k = 0; k < 9; k++) wr(64'h20 + 64'(k), p_jxx[k]);
        wr(64'h40, 8'hC0);
        wr(64'h50, 8'h00);
        wr(64'(IMEM - 5), 8'h30);
        check_en = 1'b1;
        settle();
        chk("t1 f_pc", bus.f_pc_o, 64'h0);
        chk("t1 icode", 64'(bus.f_icode_o), 64'h3);
        chk("t1 rA", 64'(bus.f_rA_o), 64'hF);
        chk("t1 rB", 64'(bus.f_rB_o), 64'h2);
        chk("t1 valC", bus.f_valC_o, 64'd10);
        chk("t1 valP", bus.f_valP_o, 64'd10);
        chk("t1 predPC", bus.f_predPC_o, 64'd10);
        chk("t1 stat", 64'(bus.f_stat_o), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t1 F_predPC", bus.F_predPC_o, 64'd10);
        redirect(64'h20);
        chk("t2 predPC", bus.f_predPC_o, 64'h100);
        chk("t2 valP", bus.f_valP_o, 64'h29);
        redirect(64'h29);
        chk("t2 f_pc", bus.f_pc_o, 64'h29);
        bus.W_icode_i = 4'h9;
        bus.W_valM_i = 64'h80;
        redirect(64'h40);
        chk("t3 f_pc", bus.f_pc_o, 64'h40);
        chk("t5 sins stat", 64'(bus.f_stat_o), 64'd4);
        chk("t5 sins valP", bus.f_valP_o, 64'h41);
        bus.W_icode_i = 4'h0;
        redirect(64'(IMEM - 5));
        chk("t5 sadr stat", 64'(bus.f_stat_o), 64'd3);
        chk("t5 sadr icode", 64'(bus.f_icode_o), 64'd1);
        chk("t5 sadr valP", bus.f_valP_o, 64'(IMEM - 4));
        redirect(64'h50);
        chk("t6 shlt stat", 64'(bus.f_stat_o), 64'd2);
        chk("t6 shlt valP", bus.f_valP_o, 64'h51);
        chk("t6 shlt predPC", bus.f_predPC_o, 64'h51);
        redirect(64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap stat", 64'(bus.f_stat_o), 64'd3);
        chk("wrap valP", bus.f_valP_o, 64'h0);
        bus.M_icode_i = 4'h0;
        @(posedge clk);
        #2;
        bus.F_stall_i = 1'b1;
        held = bus.F_predPC_o;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("t4 stall hold", bus.F_predPC_o, held);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("t4 async reset", bus.F_predPC_o, RPC);
        @(posedge clk);
        #2;
        rst = 1'b0;
        bus.F_stall_i = 1'b0;
        wr(64'(IMEM), 8'hFF);
        wr(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        redirect(64'h0);
        chk("t6 oor write icode", 64'(bus.f_icode_o), 64'h3);
        chk("t6 oor write rB", 64'(bus.f_rB_o), 64'h2);
        @(posedge clk);
        #2;
        for (int c = 0; c < 3000; c++) begin
            bus.F_stall_i = ($urandom_range(3) == 0);
            rst = ($urandom_range(299) == 0);
            bus.M_icode_i = ($urandom_range(3) == 0) ? 4'h7 : 4'($urandom);
            bus.M_Cnd_i = 1'($urandom);
            bus.M_valA_i = rpc();
            bus.W_icode_i = ($urandom_range(4) == 0) ? 4'h9 : 4'($urandom);
            bus.W_valM_i = rpc();
            bus.imem_we_i = ($urandom_range(9) == 0);
            bus.imem_waddr_i = 64'($urandom_range(1100));
            bus.imem_wdata_i = 8'($urandom);
            @(posedge clk);
            #2;
        end
        rst = 1'b0;
        bus.imem_we_i = 1'b0;
        settle();
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Y86-64 pipeline fetch stage: owns the F pipeline register (predicted PC), selects the fetch PC, reads and splits the instruction bytes, and produces the f_* bundle consumed by the D pipeline register. Sits directly upstream of the decode register and obeys F_stall_o from the pipeline controller. Contains the byte-addressed instruction memory, which has a load port for program download by the bench.

Parameters:
IMEM_BYTES, 1024, instruction memory size in bytes.
RESET_PC, 64'h0, F_predPC value after reset.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
F_stall_i  in  1  hold F register (controller F_stall_o)
M_icode_i  in  4  icode in M register
M_Cnd_i  in  1  branch condition carried in M register
M_valA_i  in  64  fall-through PC of a mispredicted jump
W_icode_i  in  4  icode in W register
W_valM_i  in  64  return address loaded by ret
imem_we_i  in  1  program-load byte write enable
imem_waddr_i  in  64  program-load byte address
imem_wdata_i  in  8  program-load byte
f_pc_o  out  64  selected fetch PC
f_icode_o  out  4  fetched icode
f_ifun_o  out  4  fetched ifun
f_rA_o  out  4  rA, or 4'hF when absent
f_rB_o  out  4  rB, or 4'hF when absent
f_valC_o  out  64  constant word, little-endian
f_valP_o  out  64  f_pc + instruction length
f_stat_o  out  3  SAOK=1, SHLT=2, SADR=3, SINS=4
f_predPC_o  out  64  predicted next PC
F_predPC_o  out  64  F register contents

Behaviour:
- Reset (async, rst_i=1): F_predPC = RESET_PC; memory contents are not cleared. Combinational outputs follow from F_predPC.
- F register: on posedge clk, when !rst_i && !F_stall_i, F_predPC <= f_predPC. When F_stall_i=1, the F register holds.
- PC select, in priority order:
  - M_icode==JXX(7) && !M_Cnd -> M_valA.
  - else W_icode==RET(9) -> W_valM.
  - else F_predPC.
- Split: byte0[7:4]=icode, byte0[3:0]=ifun.
- Instruction length:
  - HALT(0), NOP(1), RET(9): 1.
  - RRMOVQ(2), OPQ(6), PUSHQ(A), POPQ(B): 2.
  - JXX(7), CALL(8): 9.
  - IRMOVQ(3), RMMOVQ(4), MRMOVQ(5): 10.
- Register byte present for 2,3,4,5,6,A,B: rA=byte1[7:4], rB=byte1[3:0]. Otherwise rA=rB=F.
- valC:
  - Bytes 2..9 when a register byte is present (3,4,5).
  - Bytes 1..8 for JXX/CALL.
  - Otherwise 0.
- valP = f_pc + length, 64-bit with wrap.
- Instruction validity: icode>4'hB is invalid; length is treated as 1 and rA=rB=F.
- imem_error is set when f_pc + length - 1 >= IMEM_BYTES, or when that add overflows. The error takes precedence over decode:
  - outputs icode=NOP(1), ifun=0, rA=rB=F, valC=0, valP=f_pc+1.
- stat priority: imem_error -> SADR; else invalid -> SINS; else HALT -> SHLT; else SAOK.
- Prediction: f_predPC = valC for JXX/CALL, else valP. Under imem_error, f_predPC = valP.
- Memory: reads are combinational. Writes are synchronous bytes on posedge when imem_we_i=1 and imem_waddr_i<IMEM_BYTES; out-of-range writes are ignored. A write and a fetch of the same byte in one cycle: the fetch sees the old byte, and the new byte is visible next cycle.
- Stall while a redirect is pending: f_pc still reflects the M/W redirect; the F register does not capture it until the stall drops.

Test Plan:
1. Load 30F20A00000000000000 at 0; reset -> f_pc=0, icode=3, rA=F, rB=2, valC=10, valP=10, predPC=10, stat=1; next clock F_predPC_o=10.
2. jxx at 0x20 (bytes 70 00 01 00 00 00 00 00 00) -> predPC=0x100, valP=0x29. Then drive M_icode=7, M_Cnd=0, M_valA=0x29 -> f_pc=0x29.
3. M_icode=7 with M_Cnd=0 and W_icode=9 together (M_valA=0x40, W_valM=0x80) -> f_pc=0x40 (mispredict wins).
4. F_stall_i=1 for 3 cycles -> F_predPC_o is unchanged. Then assert rst_i mid-cycle -> F_predPC_o=RESET_PC immediately.
5. Byte 0xC0 at PC -> stat=4 (SINS), valP=PC+1. irmovq placed at IMEM_BYTES-5 -> stat=3 (SADR), icode=1.
6. Byte 0x00 -> stat=2 (SHLT), valP=PC+1, predPC=PC+1. Out-of-range imem write -> memory unchanged.
